pool_ctrl: RTL and testbench
============================

POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 6, feature-map width in pixels (multiple of 3).
REQ-002 SHALL have parameter IMG_H, default 4, feature-map height in pixels (multiple of 2).
REQ-003 SHALL have parameter ADDR_W, default 10, address width of both BRAM ports.
REQ-004 SHALL have parameter IN_BASE, default 0, input-map base address.
REQ-005 SHALL have parameter OUT_BASE, default 0, output-map base address.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-009 SHALL have port rd_en  output  1  input-BRAM read enable.
REQ-010 SHALL have port rd_addr  output  ADDR_W  input-BRAM read address.
REQ-011 SHALL have port rd_data  input  8  input-BRAM data, valid the cycle after rd_en.
REQ-012 SHALL have ports tap0..tap5  output  8 each  registered window pixels, driven to the external 6-input max comparator.
REQ-013 SHALL have port max_in  input  8  comparator result (unsigned max of tap0..tap5).
REQ-014 SHALL have port wr_en  output  1  output-BRAM write enable.
REQ-015 SHALL have port wr_addr  output  ADDR_W  output-BRAM write address.
REQ-016 SHALL have port wr_data  output  8  output-BRAM write data.
REQ-017 SHALL have port busy  output  1  high while a job runs.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL pool non-overlapping 2-row x 3-column windows, stride 3 horizontally and 2 vertically, in raster order (row, then col).
REQ-020 SHALL implement states IDLE, READ, WAIT, WRITE, DONE.
REQ-021 IDLE: start=1 -> READ next cycle; busy=1 from that cycle; row=col=0, out index=0.
REQ-022 READ: six consecutive cycles, k=0..5, rd_en=1, rd_addr = IN_BASE + (row + k/3)*IMG_W + col + k%3; then -> WAIT.
REQ-023 SHALL capture rd_data into tap(k) on the cycle after read k is issued; capture of tap5 happens in WAIT.
REQ-024 WAIT: rd_en=0, one cycle; then -> WRITE.
REQ-025 WRITE: one cycle, wr_en=1, wr_addr = OUT_BASE + out index, wr_data = max_in (combinational pass-through, comparator settled on the registered taps).
REQ-026 After WRITE: out index+1; col+=3; if col+3==IMG_W then col=0, row+=2; if the window just written was the last one (row==IMG_H-2 and col==IMG_W-3), -> DONE, else -> READ.
REQ-027 Each window SHALL take exactly 8 cycles (6 READ, 1 WAIT, 1 WRITE), with no idle cycles between windows.
REQ-028 DONE: one cycle, done=1, busy=0, then -> IDLE; done SHALL first go high 8*N+1 cycles after the start-sampling edge (N = (IMG_W/3)*(IMG_H/2)).
REQ-029 SHALL ignore start while busy or in DONE; no queuing.
REQ-030 rd_en and wr_en SHALL never both be high; outside READ rd_en=0, outside WRITE wr_en=0.
REQ-031 rd_addr, wr_addr and wr_data SHALL be 0 whenever their enable is low.
REQ-032 Address arithmetic SHALL be unsigned, wrapping modulo 2^ADDR_W without error.

Reset
REQ-033 On a rising clk with rst_n=0: state=IDLE; busy, done, rd_en, wr_en=0; rd_addr, wr_addr=0; tap0..tap5=0; row, col, out index=0.
REQ-034 Reset mid-job SHALL abort immediately with no further writes; a later start SHALL restart from window 0.
REQ-035 rst_n=0 SHALL override start in the same cycle.

Verification
REQ-036 Default params, input BRAM[a]=a for a=0..23, real comparator, single start pulse -> writes 8,11,20,23 to addresses 0..3; done high exactly 33 cycles after the start edge.
REQ-037 Same setup, first window read addresses -> 0,1,2,6,7,8 on consecutive cycles; wr_en in the 8th cycle.
REQ-038 Input all 0xFF except one 0x00 per window -> all outputs 0xFF; all-zero input -> all outputs 0x00.
REQ-039 start held high for 40 cycles -> exactly one job, 4 writes, one done pulse, then a second job starts from IDLE.
REQ-040 rst_n low for 1 cycle during window 2 READ -> no further wr_en, all outputs at reset values; a new start -> full correct 4-window run.

Source files
------------

// File: rtl/pool_ctrl.sv
// pool_ctrl: max-pooling sequencer for a byte-wide feature map held in BRAM.
// The map is walked in non-overlapping 2-row x 3-column windows in raster
// order. For each window, six pixels are read into tap registers. An external
// 6-input comparator reduces the taps to one value, and that result is written
// to the output BRAM. Each window takes 8 cycles: 6 READ, 1 WAIT, 1 WRITE.
//
// Ports:
//   clk, rst_n        - single clock, synchronous active-low reset
//   start             - job request, only sampled in IDLE
//   rd_en/rd_addr     - input-BRAM read port; rd_data is valid one cycle later
//   tap0..tap5        - registered window pixels, fed to the external comparator
//   max_in            - comparator result (unsigned max of tap0..tap5)
//   wr_en/wr_addr/
//   wr_data           - output-BRAM write port
//   busy              - high from the first READ until the last WRITE
//   done              - one-cycle completion pulse
module pool_ctrl #(
  parameter int IMG_W    = 6,
  parameter int IMG_H    = 4,
  parameter int ADDR_W   = 10,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tap0,
  output logic [7:0]        tap1,
  output logic [7:0]        tap2,
  output logic [7:0]        tap3,
  output logic [7:0]        tap4,
  output logic [7:0]        tap5,
  input  logic [7:0]        max_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  localparam int RW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] out_q, out_d;
  logic              cap_vld_q, cap_vld_d;
  logic [2:0]        cap_idx_q, cap_idx_d;
  logic [7:0]        tap_q [6];
  logic [7:0]        tap_d [6];

  logic              last_win;
  logic              row_end;
  logic              k_row;
  logic [1:0]        k_col;
  logic [ADDR_W-1:0] rd_addr_calc;

  assign last_win = (row_q == RW'(IMG_H - 2)) && (col_q == CW'(IMG_W - 3));
  assign row_end  = (col_q == CW'(IMG_W - 3));

  // Split k into window-row (k/3) and window-column (k%3).
  assign k_row = (k_q >= 3'd3);
  assign k_col = k_row ? 2'(k_q - 3'd3) : k_q[1:0];

  // Every term is taken to ADDR_W bits, so the address wraps modulo 2^ADDR_W.
  assign rd_addr_calc = ADDR_W'(IN_BASE)
                      + (ADDR_W'(row_q) + ADDR_W'(k_row)) * ADDR_W'(IMG_W)
                      + ADDR_W'(col_q) + ADDR_W'(k_col);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    row_d     = row_q;
    col_d     = col_q;
    out_d     = out_q;
    cap_vld_d = 1'b0;
    cap_idx_d = k_q;
    tap_d     = tap_q;

    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b0;
    done    = 1'b0;

    // Data for the read issued last cycle is on rd_data now. It is latched
    // into its tap at the end of this cycle, so tap5 is captured during WAIT.
    for (int unsigned i = 0; i < 6; i++) begin
      if (cap_vld_q && (cap_idx_q == 3'(i))) begin
        tap_d[i] = rd_data;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          k_d     = '0;
          row_d   = '0;
          col_d   = '0;
          out_d   = '0;
        end
      end
      S_READ: begin
        busy      = 1'b1;
        rd_en     = 1'b1;
        rd_addr   = rd_addr_calc;
        cap_vld_d = 1'b1;
        if (k_q == 3'd5) begin
          state_d = S_WAIT;
          k_d     = '0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_WAIT: begin
        busy    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(OUT_BASE) + out_q;
        wr_data = max_in;
        out_d   = out_q + 1'b1;
        if (last_win) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
          if (row_end) begin
            col_d = '0;
            row_d = row_q + RW'(2);
          end else begin
            col_d = col_q + CW'(3);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      out_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      tap_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      row_q     <= row_d;
      col_q     <= col_d;
      out_q     <= out_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      tap_q     <= tap_d;
    end
  end

  assign tap0 = tap_q[0];
  assign tap1 = tap_q[1];
  assign tap2 = tap_q[2];
  assign tap3 = tap_q[3];
  assign tap4 = tap_q[4];
  assign tap5 = tap_q[5];

endmodule

// File: tb/tb_pool_ctrl.sv
// Testbench for pool_ctrl: models the input BRAM (one-cycle read latency) and
// the external max comparator. Expected results come from a direct window-max
// computation over the memory image.
module tb_pool_ctrl;

  localparam int IMG_W    = 6;
  localparam int IMG_H    = 4;
  localparam int ADDR_W   = 10;
  localparam int IN_BASE  = 0;
  localparam int OUT_BASE = 0;
  localparam int NWPR     = IMG_W / 3;
  localparam int NWIN     = NWPR * (IMG_H / 2);
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int JOB_CYC  = 8 * NWIN + 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        tap0, tap1, tap2, tap3, tap4, tap5;
  logic [7:0]        max_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;

  pool_ctrl #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .ADDR_W  (ADDR_W),
    .IN_BASE (IN_BASE),
    .OUT_BASE(OUT_BASE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .tap0   (tap0),
    .tap1   (tap1),
    .tap2   (tap2),
    .tap3   (tap3),
    .tap4   (tap4),
    .tap5   (tap5),
    .max_in (max_in),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [DEPTH];

  initial rd_data = '0;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always_comb begin
    max_in = tap0;
    if (tap1 > max_in) max_in = tap1;
    if (tap2 > max_in) max_in = tap2;
    if (tap3 > max_in) max_in = tap3;
    if (tap4 > max_in) max_in = tap4;
    if (tap5 > max_in) max_in = tap5;
  end

  // Monitor: records traffic per cycle and counts protocol violations.
  int                cyc = 0;
  int                t0  = 0;
  int                prot_err = 0;
  int                wr_t[$];
  logic [ADDR_W-1:0] wr_a[$];
  logic [7:0]        wr_d[$];
  int                rd_t[$];
  logic [ADDR_W-1:0] rd_a[$];
  int                done_t[$];
  logic [7:0]        exp_d[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en) begin wr_t.push_back(cyc); wr_a.push_back(wr_addr); wr_d.push_back(wr_data); end
    if (rd_en) begin rd_t.push_back(cyc); rd_a.push_back(rd_addr); end
    if (done) done_t.push_back(cyc);
    if (rd_en && wr_en) prot_err++;
    if (!rd_en && rd_addr != '0) prot_err++;
    if (!wr_en && (wr_addr != '0 || wr_data != '0)) prot_err++;
    if (done && busy) prot_err++;
  end

  int n_total = 0;
  int n_pass  = 0;

  function automatic int win_addr(input int w, input int k);
    int r, c;
    r = (w / NWPR) * 2;
    c = (w % NWPR) * 3;
    return (IN_BASE + (r + k / 3) * IMG_W + c + k % 3) % DEPTH;
  endfunction

  function automatic void compute_expect();
    exp_d.delete();
    for (int w = 0; w < NWIN; w++) begin
      logic [7:0] m;
      m = 8'h00;
      for (int k = 0; k < 6; k++) if (mem[win_addr(w, k)] > m) m = mem[win_addr(w, k)];
      exp_d.push_back(m);
    end
  endfunction

  function automatic void clear_mon();
    wr_t.delete(); wr_a.delete(); wr_d.delete();
    rd_t.delete(); rd_a.delete(); done_t.delete();
    prot_err = 0;
  endfunction

  function automatic void fill_random();
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
  endfunction

  task automatic start_pulse(input int hold);
    @(negedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_jobs(input int ndone, input int budget, output bit ok);
    for (int i = 0; i < budget && done_t.size() < ndone; i++) begin
      @(negedge clk); #1;
    end
    ok = (done_t.size() >= ndone);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({rd_en, wr_en, busy, done} !== 4'b0000) $display("FAIL reset_ctl: got %b expected 0000", {rd_en, wr_en, busy, done});
    else n_pass++;
    n_total++;
    if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) $display("FAIL reset_bus: rd_addr %0d wr_addr %0d wr_data %0d expected 0", rd_addr, wr_addr, wr_data);
    else n_pass++;
    n_total++;
    if ({tap0, tap1, tap2, tap3, tap4, tap5} !== 48'h0) $display("FAIL reset_taps: got %h expected 0", {tap0, tap1, tap2, tap3, tap4, tap5});
    else n_pass++;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ramp();
    bit ok;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
    for (int a = 0; a < IMG_W * IMG_H; a++) mem[a] = 8'(a);
    clear_mon();
    compute_expect();
    start_pulse(1);
    n_total++;
    if (busy !== 1'b1) $display("FAIL ramp_busy: got %b expected 1", busy);
    else n_pass++;
    wait_jobs(1, JOB_CYC + 20, ok);
    n_total++;
    if (!ok) $display("FAIL ramp_timeout: got %0d done pulses expected 1", done_t.size());
    else n_pass++;
    n_total++;
    if (done_t.size() > 0 && done_t[0] - t0 !== JOB_CYC) $display("FAIL ramp_done_cycle: got %0d expected %0d", done_t[0] - t0, JOB_CYC);
    else n_pass++;
    n_total++;
    if (wr_a.size() !== NWIN) $display("FAIL ramp_wr_count: got %0d expected %0d", wr_a.size(), NWIN);
    else n_pass++;
    for (int i = 0; i < NWIN && i < wr_a.size(); i++) begin
      n_total++;
      if (wr_a[i] !== ADDR_W'((OUT_BASE + i) % DEPTH) || wr_d[i] !== exp_d[i] || wr_t[i] - t0 !== 8 * (i + 1))
        $display("FAIL ramp_write%0d: got addr %0d data %0d cyc %0d expected addr %0d data %0d cyc %0d",
                 i, wr_a[i], wr_d[i], wr_t[i] - t0, (OUT_BASE + i) % DEPTH, exp_d[i], 8 * (i + 1));
      else n_pass++;
    end
    n_total++;
    if (rd_a.size() !== 6 * NWIN) $display("FAIL ramp_rd_count: got %0d expected %0d", rd_a.size(), 6 * NWIN);
    else n_pass++;
    for (int i = 0; i < 6 * NWIN && i < rd_a.size(); i++) begin
      int et;
      et = 8 * (i / 6) + (i % 6) + 1;
      n_total++;
      if (rd_a[i] !== ADDR_W'(win_addr(i / 6, i % 6)) || rd_t[i] - t0 !== et)
        $display("FAIL ramp_read%0d: got addr %0d cyc %0d expected addr %0d cyc %0d",
                 i, rd_a[i], rd_t[i] - t0, win_addr(i / 6, i % 6), et);
      else n_pass++;
    end
    n_total++;
    if (prot_err !== 0) $display("FAIL ramp_protocol: got %0d violations expected 0", prot_err);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL ramp_idle_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_patterns();
    bit ok;
    for (int p = 0; p < 4; p++) begin
      if (p == 0) begin
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'hFF;
        for (int w = 0; w < NWIN; w++) mem[win_addr(w, $urandom_range(5, 0))] = 8'h00;
      end else if (p == 1) begin
        for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
      end else begin
        fill_random();
      end
      clear_mon();
      compute_expect();
      start_pulse(1);
      wait_jobs(1, JOB_CYC + 20, ok);
      n_total++;
      if (!ok || done_t.size() == 0 || done_t[0] - t0 !== JOB_CYC)
        $display("FAIL pat%0d_done: got %0d pulses first at %0d expected at %0d", p, done_t.size(),
                 (done_t.size() > 0) ? done_t[0] - t0 : -1, JOB_CYC);
      else n_pass++;
      n_total++;
      if (wr_a.size() !== NWIN) $display("FAIL pat%0d_wr_count: got %0d expected %0d", p, wr_a.size(), NWIN);
      else n_pass++;
      for (int i = 0; i < NWIN && i < wr_a.size(); i++) begin
        n_total++;
        if (wr_a[i] !== ADDR_W'((OUT_BASE + i) % DEPTH) || wr_d[i] !== exp_d[i])
          $display("FAIL pat%0d_write%0d: got addr %0d data %h expected addr %0d data %h",
                   p, i, wr_a[i], wr_d[i], (OUT_BASE + i) % DEPTH, exp_d[i]);
        else n_pass++;
      end
      n_total++;
      if (prot_err !== 0) $display("FAIL pat%0d_protocol: got %0d violations expected 0", p, prot_err);
      else n_pass++;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    fill_random();
    clear_mon();
    compute_expect();
    // Job ends in cycle JOB_CYC, IDLE follows, so the held start launches a
    // second job whose done lands one cycle after twice the job length.
    start_pulse(40);
    n_total++;
    if (wr_a.size() !== NWIN || done_t.size() !== 1 || busy !== 1'b1)
      $display("FAIL held_first: got writes %0d dones %0d busy %b expected %0d 1 1", wr_a.size(), done_t.size(), busy, NWIN);
    else n_pass++;
    wait_jobs(2, JOB_CYC + 20, ok);
    n_total++;
    if (!ok || done_t.size() < 2 || done_t[1] - t0 !== 2 * JOB_CYC + 1)
      $display("FAIL held_second_done: got %0d pulses second at %0d expected at %0d", done_t.size(),
               (done_t.size() > 1) ? done_t[1] - t0 : -1, 2 * JOB_CYC + 1);
    else n_pass++;
    n_total++;
    if (wr_a.size() !== 2 * NWIN) $display("FAIL held_wr_count: got %0d expected %0d", wr_a.size(), 2 * NWIN);
    else n_pass++;
    for (int i = 0; i < 2 * NWIN && i < wr_a.size(); i++) begin
      n_total++;
      if (wr_a[i] !== ADDR_W'((OUT_BASE + i % NWIN) % DEPTH) || wr_d[i] !== exp_d[i % NWIN])
        $display("FAIL held_write%0d: got addr %0d data %h expected addr %0d data %h",
                 i, wr_a[i], wr_d[i], (OUT_BASE + i % NWIN) % DEPTH, exp_d[i % NWIN]);
      else n_pass++;
    end
    n_total++;
    if (prot_err !== 0) $display("FAIL held_protocol: got %0d violations expected 0", prot_err);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_random();
    clear_mon();
    start_pulse(1);
    for (int i = 0; i < 100 && (cyc - t0) < 11; i++) begin
      @(negedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_total++;
    if ({rd_en, wr_en, busy, done} !== 4'b0000 || rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0)
      $display("FAIL mid_reset_ctl: got en/busy/done %b rd_addr %0d expected all 0", {rd_en, wr_en, busy, done}, rd_addr);
    else n_pass++;
    n_total++;
    if ({tap0, tap1, tap2, tap3, tap4, tap5} !== 48'h0) $display("FAIL mid_reset_taps: got %h expected 0", {tap0, tap1, tap2, tap3, tap4, tap5});
    else n_pass++;
    repeat (60) @(negedge clk);
    #1;
    n_total++;
    if (wr_a.size() !== 1 || done_t.size() !== 0)
      $display("FAIL mid_reset_abort: got writes %0d dones %0d expected 1 0", wr_a.size(), done_t.size());
    else n_pass++;
    fill_random();
    clear_mon();
    compute_expect();
    start_pulse(1);
    wait_jobs(1, JOB_CYC + 20, ok);
    n_total++;
    if (!ok || done_t.size() == 0 || done_t[0] - t0 !== JOB_CYC || wr_a.size() !== NWIN)
      $display("FAIL mid_restart: got dones %0d writes %0d expected 1 %0d", done_t.size(), wr_a.size(), NWIN);
    else n_pass++;
    for (int i = 0; i < NWIN && i < wr_a.size(); i++) begin
      n_total++;
      if (wr_a[i] !== ADDR_W'((OUT_BASE + i) % DEPTH) || wr_d[i] !== exp_d[i])
        $display("FAIL mid_restart_write%0d: got addr %0d data %h expected addr %0d data %h",
                 i, wr_a[i], wr_d[i], (OUT_BASE + i) % DEPTH, exp_d[i]);
      else n_pass++;
    end
    n_total++;
    if (prot_err !== 0) $display("FAIL mid_protocol: got %0d violations expected 0", prot_err);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
    test_reset();
    test_ramp();
    test_patterns();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
